// File: rtl/winograd_pe_seq_if.sv
// Feature-handshake and PE-control bundle between the issue sequencer and the
// Winograd PE core. The sequencer owns the master side.
interface winograd_pe_seq_if;
   logic feat_valid;
   logic feat_ready;
   logic pe_out_valid;
   logic in_valid;
   logic tofifo;
   logic fromfifo;
   logic bias_valid;
   logic poolop;

   modport master (
      input  feat_valid, pe_out_valid,
      output feat_ready, in_valid, tofifo, fromfifo, bias_valid, poolop
   );

   modport slave (
      output feat_valid, pe_out_valid,
      input  feat_ready, in_valid, tofifo, fromfifo, bias_valid, poolop
   );
endinterface

// File: rtl/winograd_pe_seq.sv
// Group-major issue sequencer for the Winograd PE core: bias load, per-group tile
// issue with inter-data FIFO tagging, inter-group gap, result drain.
// Optional stall counter enabled by defining SEQ_PERF_CNT_EN.
module winograd_pe_seq #(
   parameter int unsigned TILE_BIT   = 11,
   parameter int unsigned GROUP_BIT  = 8,
   parameter int unsigned FIFO_DEPTH = 1024,
   parameter int unsigned GROUP_GAP  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [TILE_BIT-1:0]  cfg_num_tiles,
   input  logic [GROUP_BIT-1:0] cfg_num_groups,
   input  logic                 cfg_poolop,
   winograd_pe_seq_if.master    bus,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [31:0]          stall_cnt
);

   localparam int RW = TILE_BIT + GROUP_BIT;
   localparam int GW = $clog2(GROUP_GAP) + 1;

   typedef enum logic [2:0] {IDLE, BIAS, RUN, GAP, DRAIN} state_t;

   state_t               state_q, state_d;
   logic [TILE_BIT-1:0]  num_tiles;
   logic [GROUP_BIT-1:0] num_groups;
   logic [RW-1:0]        total;
   logic [TILE_BIT-1:0]  tile_cnt;
   logic [GROUP_BIT-1:0] grp_cnt;
   logic [RW-1:0]        result_cnt;
   logic [GW-1:0]        gap_cnt;
   logic                 poolop_q;

   logic cfg_bad, accept, handshake, last_tile, last_group, gap_end, drain_done;

   assign cfg_bad    = (cfg_num_tiles == '0) || (cfg_num_groups == '0) ||
                       (32'(cfg_num_tiles) > FIFO_DEPTH);
   assign accept     = (state_q == IDLE) && start && !cfg_bad;
   assign handshake  = (state_q == RUN) && bus.feat_valid;
   assign last_tile  = (tile_cnt == num_tiles - TILE_BIT'(1));
   assign last_group = (grp_cnt == num_groups - GROUP_BIT'(1));
   assign gap_end    = (gap_cnt == GW'(GROUP_GAP - 1));
   assign drain_done = (state_q == DRAIN) && (result_cnt == total);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = BIAS;
         BIAS:    state_d = RUN;
         RUN:     if (handshake && last_tile) state_d = last_group ? DRAIN : GAP;
         GAP:     if (gap_end) state_d = RUN;
         DRAIN:   if (drain_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // With G==1 the single group is both first and last, so both tags drop to 0.
   assign bus.feat_ready = (state_q == RUN);
   assign bus.in_valid   = bus.feat_valid & bus.feat_ready;
   assign bus.tofifo     = bus.in_valid & ~last_group;
   assign bus.fromfifo   = bus.in_valid & (grp_cnt != '0);
   assign bus.bias_valid = (state_q == BIAS);
   assign bus.poolop     = poolop_q;
   assign busy           = (state_q != IDLE);

   always_ff @(posedge clk) begin
      if (accept) begin
         num_tiles  <= cfg_num_tiles;
         num_groups <= cfg_num_groups;
         total      <= RW'(cfg_num_tiles) * RW'(cfg_num_groups);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tile_cnt   <= '0;
         grp_cnt    <= '0;
         result_cnt <= '0;
         gap_cnt    <= '0;
         poolop_q   <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done    <= drain_done;
         err     <= (state_q == IDLE) && start && cfg_bad;
         gap_cnt <= (state_q == GAP) ? gap_cnt + GW'(1) : '0;
         if (accept) begin
            tile_cnt   <= '0;
            grp_cnt    <= '0;
            result_cnt <= '0;
            poolop_q   <= cfg_poolop;
         end else begin
            if (handshake) begin
               tile_cnt <= last_tile ? '0 : tile_cnt + TILE_BIT'(1);
               if (last_tile && !last_group) grp_cnt <= grp_cnt + GROUP_BIT'(1);
            end
            if ((state_q != IDLE) && bus.pe_out_valid)
               result_cnt <= result_cnt + RW'(1);
         end
      end
   end

`ifdef SEQ_PERF_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst)
         stall_q <= '0;
      else if (accept)
         stall_q <= '0;
      else if ((state_q == RUN) && !bus.feat_valid && (stall_q != '1))
         stall_q <= stall_q + 32'd1;
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: doc/winograd_pe_seq.md
Name: winograd_pe_seq

Overview:
- Issue-side sequencer that drives the Winograd PE core's control protocol: in_valid, tofifo, fromfifo, bias_valid and poolop.
- Accepts feature tiles from the upstream tile buffer over a valid/ready handshake and orders them as a group-major loop: for each input-channel group, every output tile once.
- Tags each group so the PE core's inter-data FIFO accumulates partial sums correctly.
- Counts PE out_valid returns and signals job completion.

Parameters:
- TILE_BIT, 11, width of num_tiles config and tile counter.
- GROUP_BIT, 8, width of num_groups config and group counter.
- FIFO_DEPTH, 1024, depth of the PE inter-data FIFO; upper bound on num_tiles.
- GROUP_GAP, 8, idle cycles inserted between groups. Must be at least 8, the PE write-after-read pipeline distance.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle job launch; sampled only in IDLE
- cfg_num_tiles  in  TILE_BIT  tiles per group, latched on start
- cfg_num_groups  in  GROUP_BIT  input-channel groups, latched on start
- cfg_poolop  in  1  pool mode, latched on start
- feat_valid  in  1  upstream tile available
- feat_ready  out  1  sequencer accepts tile this cycle
- pe_out_valid  in  1  PE core result strobe
- in_valid  out  1  PE issue strobe
- tofifo  out  1  PE writes result to inter-data FIFO
- fromfifo  out  1  PE adds inter-data FIFO entry
- bias_valid  out  1  one-cycle bias load strobe
- poolop  out  1  latched pool mode
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse at job end
- err  out  1  one-cycle pulse on illegal config
- stall_cnt  out  32  feature-starved cycles (see Optional Feature)

Behaviour:
- Reset: state IDLE. All outputs 0, including counters and poolop.
- Reset mid-job aborts the job immediately; no done is pulsed.
- States: IDLE, BIAS, RUN, GAP, DRAIN.
- IDLE, on start:
  - If cfg_num_tiles==0, cfg_num_groups==0, or cfg_num_tiles>FIFO_DEPTH: pulse err next cycle and stay IDLE.
  - Otherwise latch config, clear tile/group/result counters, and go to BIAS.
- start while busy is ignored.
- BIAS: bias_valid=1 for exactly one cycle, then RUN.
- RUN:
  - feat_ready=1. in_valid = feat_valid & feat_ready.
  - Each handshake increments tile_cnt.
  - tofifo and fromfifo are combinational from group index g (G=num_groups) and valid only while in_valid=1; they are 0 otherwise.
    - G==1: tofifo=0, fromfifo=0.
    - g==0, G>1: tofifo=1, fromfifo=0.
    - 0<g<G-1: tofifo=1, fromfifo=1.
    - g==G-1, G>1: tofifo=0, fromfifo=1.
  - On the handshake with tile_cnt==num_tiles-1: tile_cnt→0.
    - If g<G-1: g++ and go to GAP.
    - Else go to DRAIN.
- GAP: feat_ready=0 for exactly GROUP_GAP cycles, then RUN.
- DRAIN: feat_ready=0. Wait until result_cnt==num_tiles*num_groups, then pulse done, go to IDLE, busy falls the same cycle done pulses.
- result_cnt:
  - Counts pe_out_valid in every non-IDLE state; width TILE_BIT+GROUP_BIT.
  - A pe_out_valid arriving in the same cycle as the final issue is counted.
  - pe_out_valid in IDLE is ignored.
- poolop holds the latched value for the whole job and stays valid until the next start.
- No downstream backpressure: once issued, a tile is never retracted.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined: stall_cnt increments each RUN cycle with feat_valid=0, saturates at 2^32-1, clears on accepted start.
- Undefined: stall_cnt is constant 0 and no counter logic is synthesised.

Test Plan:
- Single group: start with tiles=4, groups=1, feat_valid held high. Expect bias_valid at cycle 1, in_valid on 4 consecutive cycles, tofifo=fromfifo=0 throughout. Return 4 pe_out_valid → done pulse once, busy=0.
- Three groups: tiles=2, groups=3. Expect issues tagged (to,from) = (1,0)x2, then (1,1)x2, then (0,1)x2, with exactly 8 idle cycles between groups. done only after the 6th pe_out_valid.
- Starved input: tiles=3, groups=1, feat_valid toggling 1,0,0,1,0,1. Expect in_valid only on the high cycles. With SEQ_PERF_CNT_EN, stall_cnt=3 at done.
- Illegal config: tiles=0, then tiles=1025. Expect err pulse each time, busy stays 0, no in_valid. A subsequent legal start completes normally.
- Reset mid-job: assert rst during group 1 RUN. Next cycle all outputs are 0 and state is IDLE, no done pulse. A fresh job afterwards completes with the correct counts.
- start pulsed while busy: no effect on counters or config; the original job completes with its own counts.
